// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops, wakes operands from two CDBs, issues one ready op per cycle.
// Optional macro RS_ALU_AGE_ORDER_EN selects oldest-ready issue; otherwise the lowest-index ready entry issues.
module rs_alu #(
   parameter int RS_SIZE = 8,
   parameter int ROB_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy_i,
   input  logic             rollback_i,
   input  logic             disp_en_i,
   input  logic [6:0]       disp_opcode_i,
   input  logic [2:0]       disp_funct3_i,
   input  logic             disp_funct7_i,
   input  logic [31:0]      disp_val1_i,
   input  logic [31:0]      disp_val2_i,
   input  logic [31:0]      disp_imm_i,
   input  logic [31:0]      disp_pc_i,
   input  logic             disp_q1_busy_i,
   input  logic             disp_q2_busy_i,
   input  logic [ROB_W-1:0] disp_q1_i,
   input  logic [ROB_W-1:0] disp_q2_i,
   input  logic [ROB_W-1:0] disp_rob_pos_i,
   input  logic             alu_cdb_en_i,
   input  logic [ROB_W-1:0] alu_cdb_rob_pos_i,
   input  logic [31:0]      alu_cdb_val_i,
   input  logic             lsb_cdb_en_i,
   input  logic [ROB_W-1:0] lsb_cdb_rob_pos_i,
   input  logic [31:0]      lsb_cdb_val_i,
   output logic             alu_en_o,
   output logic [6:0]       alu_opcode_o,
   output logic [2:0]       alu_funct3_o,
   output logic             alu_funct7_o,
   output logic [31:0]      alu_val1_o,
   output logic [31:0]      alu_val2_o,
   output logic [31:0]      alu_imm_o,
   output logic [31:0]      alu_pc_o,
   output logic [ROB_W-1:0] alu_rob_pos_o,
   output logic             rs_full_o
);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [RS_SIZE-1:0] q1_busy_q, q1_busy_d;
   logic [RS_SIZE-1:0] q2_busy_q, q2_busy_d;
   logic [6:0]         op_q    [RS_SIZE];
   logic [6:0]         op_d    [RS_SIZE];
   logic [2:0]         f3_q    [RS_SIZE];
   logic [2:0]         f3_d    [RS_SIZE];
   logic [RS_SIZE-1:0] f7_q, f7_d;
   logic [31:0]        val1_q  [RS_SIZE];
   logic [31:0]        val1_d  [RS_SIZE];
   logic [31:0]        val2_q  [RS_SIZE];
   logic [31:0]        val2_d  [RS_SIZE];
   logic [31:0]        imm_q   [RS_SIZE];
   logic [31:0]        imm_d   [RS_SIZE];
   logic [31:0]        pc_q    [RS_SIZE];
   logic [31:0]        pc_d    [RS_SIZE];
   logic [ROB_W-1:0]   q1_q    [RS_SIZE];
   logic [ROB_W-1:0]   q1_d    [RS_SIZE];
   logic [ROB_W-1:0]   q2_q    [RS_SIZE];
   logic [ROB_W-1:0]   q2_d    [RS_SIZE];
   logic [ROB_W-1:0]   rob_q   [RS_SIZE];
   logic [ROB_W-1:0]   rob_d   [RS_SIZE];

   logic               alu_en_q, alu_en_d;
   logic [6:0]         alu_opcode_q, alu_opcode_d;
   logic [2:0]         alu_funct3_q, alu_funct3_d;
   logic               alu_funct7_q, alu_funct7_d;
   logic [31:0]        alu_val1_q, alu_val1_d;
   logic [31:0]        alu_val2_q, alu_val2_d;
   logic [31:0]        alu_imm_q, alu_imm_d;
   logic [31:0]        alu_pc_q, alu_pc_d;
   logic [ROB_W-1:0]   alu_rob_pos_q, alu_rob_pos_d;

   logic [RS_SIZE-1:0] ready;
   logic [RS_SIZE-1:0] q1_hit_alu, q1_hit_lsb, q2_hit_alu, q2_hit_lsb;
   logic               fwd1_alu, fwd1_lsb, fwd2_alu, fwd2_lsb;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   issue_idx;
   logic               issue_vld;

   assign rs_full_o = &busy_q;

   genvar gi;
   generate
      for (gi = 0; gi < RS_SIZE; gi++) begin : g_wake
         assign ready[gi]      = busy_q[gi] & ~q1_busy_q[gi] & ~q2_busy_q[gi];
         assign q1_hit_alu[gi] = busy_q[gi] & q1_busy_q[gi] & alu_cdb_en_i & (q1_q[gi] == alu_cdb_rob_pos_i);
         assign q1_hit_lsb[gi] = busy_q[gi] & q1_busy_q[gi] & lsb_cdb_en_i & (q1_q[gi] == lsb_cdb_rob_pos_i);
         assign q2_hit_alu[gi] = busy_q[gi] & q2_busy_q[gi] & alu_cdb_en_i & (q2_q[gi] == alu_cdb_rob_pos_i);
         assign q2_hit_lsb[gi] = busy_q[gi] & q2_busy_q[gi] & lsb_cdb_en_i & (q2_q[gi] == lsb_cdb_rob_pos_i);
      end
   endgenerate

   // A dispatching operand whose producer broadcasts this very cycle enters already resolved.
   assign fwd1_alu = disp_q1_busy_i & alu_cdb_en_i & (disp_q1_i == alu_cdb_rob_pos_i);
   assign fwd1_lsb = disp_q1_busy_i & lsb_cdb_en_i & (disp_q1_i == lsb_cdb_rob_pos_i);
   assign fwd2_alu = disp_q2_busy_i & alu_cdb_en_i & (disp_q2_i == alu_cdb_rob_pos_i);
   assign fwd2_lsb = disp_q2_busy_i & lsb_cdb_en_i & (disp_q2_i == lsb_cdb_rob_pos_i);

   always_comb begin
      free_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) free_idx = IDX_W'(i);
      end
   end

`ifdef RS_ALU_AGE_ORDER_EN
   // age_q is the number of older busy entries, so ages of busy entries are unique and dense.
   logic [IDX_W-1:0] age_q [RS_SIZE];
   logic [IDX_W-1:0] age_d [RS_SIZE];
   logic [IDX_W:0]   busy_cnt;
   logic [IDX_W:0]   new_age;

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + {{IDX_W{1'b0}}, busy_q[i]};
   end

   assign new_age = busy_cnt - {{IDX_W{1'b0}}, issue_vld};

   always_comb begin
      issue_vld = 1'b0;
      issue_idx = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (ready[i] && (!issue_vld || age_q[i] < age_q[issue_idx])) begin
            issue_vld = 1'b1;
            issue_idx = IDX_W'(i);
         end
      end
   end
`else
   always_comb begin
      issue_vld = 1'b0;
      issue_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (ready[i]) begin
            issue_vld = 1'b1;
            issue_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      busy_d        = busy_q;
      q1_busy_d     = q1_busy_q;
      q2_busy_d     = q2_busy_q;
      op_d          = op_q;
      f3_d          = f3_q;
      f7_d          = f7_q;
      val1_d        = val1_q;
      val2_d        = val2_q;
      imm_d         = imm_q;
      pc_d          = pc_q;
      q1_d          = q1_q;
      q2_d          = q2_q;
      rob_d         = rob_q;
      alu_en_d      = 1'b0;
      alu_opcode_d  = alu_opcode_q;
      alu_funct3_d  = alu_funct3_q;
      alu_funct7_d  = alu_funct7_q;
      alu_val1_d    = alu_val1_q;
      alu_val2_d    = alu_val2_q;
      alu_imm_d     = alu_imm_q;
      alu_pc_d      = alu_pc_q;
      alu_rob_pos_d = alu_rob_pos_q;
`ifdef RS_ALU_AGE_ORDER_EN
      age_d         = age_q;
`endif
      if (rollback_i) begin
         busy_d = '0;
      end else begin
         if (issue_vld) begin
            alu_en_d          = 1'b1;
            alu_opcode_d      = op_q[issue_idx];
            alu_funct3_d      = f3_q[issue_idx];
            alu_funct7_d      = f7_q[issue_idx];
            alu_val1_d        = val1_q[issue_idx];
            alu_val2_d        = val2_q[issue_idx];
            alu_imm_d         = imm_q[issue_idx];
            alu_pc_d          = pc_q[issue_idx];
            alu_rob_pos_d     = rob_q[issue_idx];
            busy_d[issue_idx] = 1'b0;
`ifdef RS_ALU_AGE_ORDER_EN
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i] && age_q[i] > age_q[issue_idx]) age_d[i] = age_q[i] - 1'b1;
            end
`endif
         end
         for (int i = 0; i < RS_SIZE; i++) begin
            if (q1_hit_alu[i]) begin
               val1_d[i]    = alu_cdb_val_i;
               q1_busy_d[i] = 1'b0;
            end else if (q1_hit_lsb[i]) begin
               val1_d[i]    = lsb_cdb_val_i;
               q1_busy_d[i] = 1'b0;
            end
            if (q2_hit_alu[i]) begin
               val2_d[i]    = alu_cdb_val_i;
               q2_busy_d[i] = 1'b0;
            end else if (q2_hit_lsb[i]) begin
               val2_d[i]    = lsb_cdb_val_i;
               q2_busy_d[i] = 1'b0;
            end
         end
         if (disp_en_i && !rs_full_o) begin
            busy_d[free_idx]    = 1'b1;
            op_d[free_idx]      = disp_opcode_i;
            f3_d[free_idx]      = disp_funct3_i;
            f7_d[free_idx]      = disp_funct7_i;
            imm_d[free_idx]     = disp_imm_i;
            pc_d[free_idx]      = disp_pc_i;
            rob_d[free_idx]     = disp_rob_pos_i;
            q1_d[free_idx]      = disp_q1_i;
            q2_d[free_idx]      = disp_q2_i;
            q1_busy_d[free_idx] = disp_q1_busy_i & ~fwd1_alu & ~fwd1_lsb;
            q2_busy_d[free_idx] = disp_q2_busy_i & ~fwd2_alu & ~fwd2_lsb;
            val1_d[free_idx]    = fwd1_alu ? alu_cdb_val_i : (fwd1_lsb ? lsb_cdb_val_i : disp_val1_i);
            val2_d[free_idx]    = fwd2_alu ? alu_cdb_val_i : (fwd2_lsb ? lsb_cdb_val_i : disp_val2_i);
`ifdef RS_ALU_AGE_ORDER_EN
            age_d[free_idx]     = new_age[IDX_W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q        <= '0;
         q1_busy_q     <= '0;
         q2_busy_q     <= '0;
         f7_q          <= '0;
         alu_en_q      <= 1'b0;
         alu_opcode_q  <= '0;
         alu_funct3_q  <= '0;
         alu_funct7_q  <= 1'b0;
         alu_val1_q    <= '0;
         alu_val2_q    <= '0;
         alu_imm_q     <= '0;
         alu_pc_q      <= '0;
         alu_rob_pos_q <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]   <= '0;
            f3_q[i]   <= '0;
            val1_q[i] <= '0;
            val2_q[i] <= '0;
            imm_q[i]  <= '0;
            pc_q[i]   <= '0;
            q1_q[i]   <= '0;
            q2_q[i]   <= '0;
            rob_q[i]  <= '0;
`ifdef RS_ALU_AGE_ORDER_EN
            age_q[i]  <= '0;
`endif
         end
      end else if (rdy_i) begin
         busy_q        <= busy_d;
         q1_busy_q     <= q1_busy_d;
         q2_busy_q     <= q2_busy_d;
         f7_q          <= f7_d;
         op_q          <= op_d;
         f3_q          <= f3_d;
         val1_q        <= val1_d;
         val2_q        <= val2_d;
         imm_q         <= imm_d;
         pc_q          <= pc_d;
         q1_q          <= q1_d;
         q2_q          <= q2_d;
         rob_q         <= rob_d;
         alu_en_q      <= alu_en_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_funct3_q  <= alu_funct3_d;
         alu_funct7_q  <= alu_funct7_d;
         alu_val1_q    <= alu_val1_d;
         alu_val2_q    <= alu_val2_d;
         alu_imm_q     <= alu_imm_d;
         alu_pc_q      <= alu_pc_d;
         alu_rob_pos_q <= alu_rob_pos_d;
`ifdef RS_ALU_AGE_ORDER_EN
         age_q         <= age_d;
`endif
      end
   end

   assign alu_en_o      = alu_en_q;
   assign alu_opcode_o  = alu_opcode_q;
   assign alu_funct3_o  = alu_funct3_q;
   assign alu_funct7_o  = alu_funct7_q;
   assign alu_val1_o    = alu_val1_q;
   assign alu_val2_o    = alu_val2_q;
   assign alu_imm_o     = alu_imm_q;
   assign alu_pc_o      = alu_pc_q;
   assign alu_rob_pos_o = alu_rob_pos_q;

endmodule
